// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive sequencer.
package uart_pkg;
    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DRAIN} ctrl_state_e;
    localparam int OVERSAMPLE = 16;
    function automatic int frame_bits(input int data_size);
        return data_size + 2;
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divisor counter producing a one-clk oversampling strobe while run is high.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic                 s_tick
);
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_m1;
    // >= lets a shrinking divisor terminate on the next clk instead of wrapping
    assign div_m1 = (baud_div == '0) ? '0 : baud_div - 1'b1;
    assign s_tick = run && (cnt_q >= div_m1);
    assign cnt_d  = (!run || s_tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences uart_rx (tick, start permit), captures bytes into the RX FIFO,
// and flags overrun and character-timeout conditions.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_SIZE     = 8,
    parameter int DIV_WIDTH     = 16,
    parameter int TIMEOUT_CHARS = 4,
    parameter int OVR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [DIV_WIDTH-1:0]     baud_div,
    input  logic                     rx_line,
    output logic                     s_tick,
    output logic                     rx_start,
    input  logic [DATA_SIZE-1:0]     rx_data,
    input  logic                     rx_done_tick,
    output logic                     fifo_wr_en,
    output logic [DATA_SIZE-1:0]     fifo_wr_data,
    input  logic                     fifo_full,
    input  logic                     fifo_empty,
    input  logic                     clr_err,
    output logic                     overrun_err,
    output logic [OVR_CNT_WIDTH-1:0] ovr_count,
    output logic                     timeout_irq
);
    localparam int DRAIN_TICKS = OVERSAMPLE * frame_bits(DATA_SIZE);
    localparam int TO_TICKS    = TIMEOUT_CHARS * DRAIN_TICKS;
    localparam int DW          = $clog2(DRAIN_TICKS + 1);
    localparam int TW          = $clog2(TO_TICKS + 1);

    ctrl_state_e            state_q, state_d;
    logic [DW-1:0]          drain_cnt_q, drain_cnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic [DATA_SIZE-1:0]   cap_data_q, cap_data_d;
    logic                   cap_valid_q, cap_valid_d;
    logic                   ovr_err_q, ovr_err_d;
    logic [OVR_CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d, ovr_inc;
    logic                   irq_q, irq_d;
    logic                   ticking, done, accept, overrun, drain_end;
    logic                   to_clr, to_hit, to_event;

    uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (ticking),
        .baud_div (baud_div),
        .s_tick   (s_tick)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= ST_OFF;
        else          state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF:   if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_DRAIN;
            ST_DRAIN: if (enable) state_d = ST_RUN;
                      else if (drain_end) state_d = ST_OFF;
            default:  state_d = ST_OFF;
        endcase
    end

    always_comb begin
        ticking  = state_q != ST_OFF;
        rx_start = (state_q == ST_RUN) && (!cap_valid_q || fifo_wr_en);
    end

    // rx_done_tick is a level lasting a tick period; qualify it to a single clk
    assign done        = rx_done_tick && s_tick;
    assign fifo_wr_en  = cap_valid_q && !fifo_full;
    assign fifo_wr_data = cap_data_q;
    assign accept      = done && (!cap_valid_q || fifo_wr_en);
    assign overrun     = done && cap_valid_q && !fifo_wr_en;
    assign drain_end   = s_tick && (drain_cnt_q == DW'(DRAIN_TICKS - 1));
    assign ovr_inc     = (&ovr_cnt_q) ? ovr_cnt_q : ovr_cnt_q + 1'b1;

    assign to_clr   = done || !rx_line || fifo_empty || (state_q == ST_OFF);
    assign to_hit   = to_cnt_q == TW'(TO_TICKS - 1);
    assign to_event = !to_clr && s_tick && to_hit;

    always_comb begin
        drain_cnt_d = (state_q != ST_DRAIN || enable) ? '0
                    : s_tick ? drain_cnt_q + 1'b1 : drain_cnt_q;
        cap_data_d  = accept ? rx_data : cap_data_q;
        cap_valid_d = accept || (cap_valid_q && !fifo_wr_en);
        ovr_err_d   = overrun || (ovr_err_q && !clr_err);
        ovr_cnt_d   = overrun ? (clr_err ? OVR_CNT_WIDTH'(1) : ovr_inc)
                    : clr_err ? '0 : ovr_cnt_q;
        to_cnt_d    = to_clr ? '0 : (s_tick && !to_hit) ? to_cnt_q + 1'b1 : to_cnt_q;
        irq_d       = to_event || (irq_q && !clr_err && !fifo_empty);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            drain_cnt_q <= '0;
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
            ovr_err_q   <= 1'b0;
            ovr_cnt_q   <= '0;
            to_cnt_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
            cap_data_q  <= cap_data_d;
            cap_valid_q <= cap_valid_d;
            ovr_err_q   <= ovr_err_d;
            ovr_cnt_q   <= ovr_cnt_d;
            to_cnt_q    <= to_cnt_d;
            irq_q       <= irq_d;
        end

    assign overrun_err = ovr_err_q;
    assign ovr_count   = ovr_cnt_q;
    assign timeout_irq = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench; the bench plays uart_rx and the FIFO around the sequencer.
module tb_uart_rx_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0, rx_line = 1'b1;
    logic        rx_done_tick = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b1, clr_err = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic [7:0]  rx_data = 8'h00;
    logic        s_tick, rx_start, fifo_wr_en, overrun_err, timeout_irq;
    logic [7:0]  fifo_wr_data, ovr_count;
    int          n_checks = 0, n_errors = 0, n_writes = 0;
    logic [7:0]  exp_q[$];

    uart_rx_ctrl dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .baud_div(baud_div),
        .rx_line(rx_line), .s_tick(s_tick), .rx_start(rx_start), .rx_data(rx_data),
        .rx_done_tick(rx_done_tick), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .clr_err(clr_err),
        .overrun_err(overrun_err), .ovr_count(ovr_count), .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge just before the next s_tick edge
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_tick && n < 100);
        if (!s_tick) check("tick_wait_expired", s_tick, 1);
    endtask

    task automatic count_ticks(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (s_tick) cnt++;
        end
    endtask

    // Raise rx_done_tick for one full tick period; optionally release full or pulse clr_err
    task automatic done_byte(input logic [7:0] d, input bit exp, input bit rel_full, input bit clr);
        wait_tick();
        @(posedge clk); #1;
        rx_done_tick = 1'b1;
        rx_data = d;
        if (exp) exp_q.push_back(d);
        if (rel_full) begin
            repeat (3) @(posedge clk);
            #1 fifo_full = 1'b0;
        end
        wait_tick();
        if (clr) #1 clr_err = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
        clr_err = 1'b0;
        @(negedge clk);
        check("wr_latency", fifo_wr_en, !fifo_full);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit exp);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = bits[i];
            repeat (16) wait_tick();
        end
        rx_line = 1'b1;
        done_byte(d, exp, 1'b0, 1'b0);
    endtask

    always @(negedge clk)
        if (reset_n && fifo_wr_en) begin
            n_writes++;
            if (exp_q.size() == 0) check("wr_unexpected", {24'd0, fifo_wr_data}, 32'h100);
            else check("wr_data", fifo_wr_data, exp_q.pop_front());
        end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cnt, w0;
        #2;
        check("rst_s_tick", s_tick, 0);
        check("rst_rx_start", rx_start, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_overrun", overrun_err, 0);
        check("rst_ovr_count", ovr_count, 0);
        check("rst_timeout", timeout_irq, 0);
        @(negedge clk) reset_n = 1'b1;
        count_ticks(10, cnt);
        check("off_no_tick", cnt, 0);

        // T1: divisor behaviour and drain
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1;
        check("run_rx_start", rx_start, 1);
        count_ticks(40, cnt);
        check("div4_ticks", cnt, 10);
        @(posedge clk); #1 baud_div = 16'd0;
        count_ticks(20, cnt);
        check("div0_ticks", cnt, 20);
        @(posedge clk); #1 baud_div = 16'd4;
        @(posedge clk); #1 enable = 1'b0;
        @(posedge clk); #1;
        check("drain_rx_start", rx_start, 0);
        count_ticks(800, cnt);
        check("drain_ticks", cnt, 160);
        count_ticks(40, cnt);
        check("off_after_drain", cnt, 0);

        // T2: one frame, one write
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1;
        w0 = n_writes;
        send_frame(8'hA5, 1'b1);
        repeat (5) @(negedge clk);
        check("t2_writes", n_writes, w0 + 1);

        // T3: FIFO full, overrun, release
        @(posedge clk); #1 fifo_full = 1'b1;
        w0 = n_writes;
        send_frame(8'h3C, 1'b1);
        check("t3_rx_start_held", rx_start, 0);
        done_byte(8'h7E, 1'b0, 1'b0, 1'b0);
        check("t3_overrun", overrun_err, 1);
        check("t3_ovr_count", ovr_count, 1);
        check("t3_no_write", n_writes, w0);
        @(posedge clk); #1 fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_write_after_release", n_writes, w0 + 1);
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        check("t3_clr_overrun", overrun_err, 0);
        check("t3_clr_count", ovr_count, 0);

        // done in the same clk as a push: accepted, no overrun
        @(posedge clk); #1 fifo_full = 1'b1;
        w0 = n_writes;
        done_byte(8'h21, 1'b1, 1'b0, 1'b0);
        done_byte(8'h42, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("same_clk_no_overrun", overrun_err, 0);
        check("same_clk_writes", n_writes, w0 + 2);

        // clr_err coinciding with an overrun: the set wins
        @(posedge clk); #1 fifo_full = 1'b1;
        done_byte(8'h55, 1'b1, 1'b0, 1'b0);
        done_byte(8'h66, 1'b0, 1'b0, 1'b1);
        check("set_wins_overrun", overrun_err, 1);
        @(posedge clk); #1 fifo_full = 1'b0;
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;

        // T4: character timeout
        fifo_empty = 1'b0;
        done_byte(8'h11, 1'b1, 1'b0, 1'b0);
        repeat (639) wait_tick();
        @(posedge clk); #1;
        check("to_not_early", timeout_irq, 0);
        wait_tick();
        @(posedge clk); #1;
        check("to_rises_640", timeout_irq, 1);
        clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        check("to_clr_err", timeout_irq, 0);
        wait_tick();
        @(posedge clk); #1;
        check("to_reasserts", timeout_irq, 1);
        fifo_empty = 1'b1;
        @(posedge clk); #1;
        check("to_clr_empty", timeout_irq, 0);

        // T5: disable mid-frame, frame still completes and is pushed
        w0 = n_writes;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                int dc;
                repeat (40) wait_tick();
                @(posedge clk); #1 enable = 1'b0;
                @(posedge clk); #1;
                check("t5_rx_start_off", rx_start, 0);
                count_ticks(800, dc);
                check("t5_drain_ticks", dc, 160);
            end
        join
        check("t5_pushed", n_writes, w0 + 1);
        count_ticks(40, cnt);
        check("t5_off", cnt, 0);
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1;
        check("t5_resume_rx_start", rx_start, 1);
        count_ticks(40, cnt);
        check("t5_resume_ticks", cnt, 10);

        // T6: reset with a held byte and a frame in flight
        @(posedge clk); #1 fifo_full = 1'b1;
        done_byte(8'h99, 1'b0, 1'b0, 1'b0);
        rx_line = 1'b0;
        repeat (5) wait_tick();
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        check("t6_s_tick", s_tick, 0);
        check("t6_rx_start", rx_start, 0);
        check("t6_wr_en", fifo_wr_en, 0);
        check("t6_wr_data", fifo_wr_data, 0);
        check("t6_overrun", overrun_err, 0);
        check("t6_timeout", timeout_irq, 0);
        w0 = n_writes;
        fifo_full = 1'b0;
        rx_line = 1'b1;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (50) @(negedge clk);
        check("t6_no_write", n_writes, w0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
